// File: rtl/gfp8_pkg.sv
// Shared GFP8 types and constants for the native-vector accumulate path.
// Imported by the accumulator, its alignment adder and the bus interface.
package gfp8_pkg;

  localparam int GFP8_EXP_W    = 8;
  localparam int GFP8_NV_MAN_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } accum_state_e;

  typedef struct packed {
    logic signed [GFP8_NV_MAN_W-1:0] mantissa;
    logic signed [GFP8_EXP_W-1:0]    exponent;
  } gfp_result_t;

endpackage

// File: rtl/gfp8_nv_accum_if.sv
// Job control, NV beat input and result handshake of gfp8_nv_accum.
// master drives the job/beat/ready side; slave is the accumulator.
interface gfp8_nv_accum_if
  import gfp8_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int OUT_W = 32
);

  logic                            i_start;
  logic [CNT_W-1:0]                i_num_nv;
  logic                            i_nv_valid;
  logic signed [GFP8_NV_MAN_W-1:0] i_nv_mantissa;
  logic signed [GFP8_EXP_W-1:0]    i_nv_exponent;
  logic                            o_busy;
  logic                            o_result_valid;
  logic                            i_result_ready;
  logic signed [OUT_W-1:0]         o_result_mantissa;
  logic signed [GFP8_EXP_W-1:0]    o_result_exponent;
  logic                            o_sat;
  logic                            o_err_drop;

  modport master (
    output i_start, i_num_nv, i_nv_valid, i_nv_mantissa, i_nv_exponent, i_result_ready,
    input  o_busy, o_result_valid, o_result_mantissa, o_result_exponent, o_sat, o_err_drop
  );

  modport slave (
    input  i_start, i_num_nv, i_nv_valid, i_nv_mantissa, i_nv_exponent, i_result_ready,
    output o_busy, o_result_valid, o_result_mantissa, o_result_exponent, o_sat, o_err_drop
  );

endinterface

// File: rtl/gfp_align_add.sv
// Combinational GFP align-and-add: the smaller-exponent operand is shifted
// right onto the larger exponent, then summed with saturation to ACC_W.
module gfp_align_add
  import gfp8_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0]      i_a_man,
  input  logic signed [GFP8_EXP_W-1:0] i_a_exp,
  input  logic signed [ACC_W-1:0]      i_b_man,
  input  logic signed [GFP8_EXP_W-1:0] i_b_exp,
  output logic signed [ACC_W-1:0]      o_sum,
  output logic signed [GFP8_EXP_W-1:0] o_exp,
  output logic                         o_sat
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                        w_a_big;
  logic [GFP8_EXP_W:0]         w_diff;
  logic signed [ACC_W-1:0]     w_big;
  logic signed [ACC_W-1:0]     w_small;
  logic signed [ACC_W-1:0]     w_small_sh;
  logic [ACC_W:0]              w_sum_wide;

  // NOTE: every variable assigned in always_comb gets a default on entry so no path can infer a latch.
  always_comb begin
    w_a_big    = (i_a_exp >= i_b_exp);
    w_diff     = '0;
    w_big      = i_a_man;
    w_small    = i_b_man;
    o_exp      = i_a_exp;
    w_small_sh = '0;

    // Both exponents widened by one bit, so the difference is exact in 0..255.
    if (w_a_big) begin
      w_diff  = {i_a_exp[GFP8_EXP_W-1], i_a_exp} - {i_b_exp[GFP8_EXP_W-1], i_b_exp};
    end else begin
      w_diff  = {i_b_exp[GFP8_EXP_W-1], i_b_exp} - {i_a_exp[GFP8_EXP_W-1], i_a_exp};
      w_big   = i_b_man;
      w_small = i_a_man;
      o_exp   = i_b_exp;
    end

    // NOTE: kept out of a ?: with an unsized '0 arm, which would turn the operand unsigned and make >>> logical.
    if (32'(w_diff) < ACC_W) begin
      w_small_sh = w_small >>> w_diff;
    end

    w_sum_wide = {w_big[ACC_W-1], w_big} + {w_small_sh[ACC_W-1], w_small_sh};
    o_sat      = (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]);
    if (!o_sat) begin
      o_sum = w_sum_wide[ACC_W-1:0];
    end else if (w_sum_wide[ACC_W]) begin
      o_sum = ACC_MIN;
    end else begin
      o_sum = ACC_MAX;
    end
  end

endmodule

// File: rtl/gfp8_nv_accum.sv
// Accumulates a programmed number of NV dot results along K into one GFP
// result, presented on a valid/ready handshake to the result writer.
module gfp8_nv_accum
  import gfp8_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8,
  parameter int OUT_W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  gfp8_nv_accum_if.slave bus
);

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  accum_state_e                 r_state;
  accum_state_e                 w_next_state;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [GFP8_EXP_W-1:0] r_exp;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_seen_beat;
  logic                         r_sat;
  logic                         r_err_drop;

  logic                         w_accept_start;
  logic                         w_beat;
  logic                         w_last_beat;
  logic signed [ACC_W-1:0]      w_beat_man;
  logic signed [ACC_W-1:0]      w_sum;
  logic signed [GFP8_EXP_W-1:0] w_sum_exp;
  logic                         w_sum_sat;
  logic                         w_clip_hi;
  logic                         w_clip_lo;
  logic signed [OUT_W-1:0]      w_out_man;

  // A new job is taken in IDLE, or in DONE on the cycle the result leaves.
  assign w_accept_start = bus.i_start &&
                          ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.i_result_ready));
  assign w_beat         = bus.i_nv_valid && (r_state == ST_ACCUM);
  assign w_last_beat    = w_beat && (r_cnt == CNT_W'(1));
  assign w_beat_man     = {{(ACC_W-GFP8_NV_MAN_W){bus.i_nv_mantissa[GFP8_NV_MAN_W-1]}},
                           bus.i_nv_mantissa};

  gfp_align_add #(.ACC_W(ACC_W)) u_align_add (
    .i_a_man (r_acc),
    .i_a_exp (r_exp),
    .i_b_man (w_beat_man),
    .i_b_exp (bus.i_nv_exponent),
    .o_sum   (w_sum),
    .o_exp   (w_sum_exp),
    .o_sat   (w_sum_sat)
  );

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_start) begin
          w_next_state = (bus.i_num_nv == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_accept_start) begin
          w_next_state = (bus.i_num_nv == '0) ? ST_DONE : ST_ACCUM;
        end else if (bus.i_result_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc       <= '0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_seen_beat <= 1'b0;
      r_sat       <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      if (bus.i_nv_valid && (r_state != ST_ACCUM)) begin
        r_err_drop <= 1'b1;
      end

      if (w_accept_start) begin
        r_cnt       <= bus.i_num_nv;
        r_seen_beat <= 1'b0;
        r_acc       <= '0;
        r_exp       <= '0;
        r_sat       <= 1'b0;
      end else if (w_beat) begin
        r_cnt       <= r_cnt - CNT_W'(1);
        r_seen_beat <= 1'b1;
        if (!r_seen_beat) begin
          r_acc <= w_beat_man;
          r_exp <= bus.i_nv_exponent;
        end else begin
          r_acc <= w_sum;
          r_exp <= w_sum_exp;
          r_sat <= r_sat | w_sum_sat;
        end
      end
    end
  end

  // Clip the accumulator into the signed OUT_W output range.
  always_comb begin
    w_clip_hi = (r_acc > OUT_MAX);
    w_clip_lo = (r_acc < OUT_MIN);
    if (w_clip_hi) begin
      w_out_man = OUT_MAX[OUT_W-1:0];
    end else if (w_clip_lo) begin
      w_out_man = OUT_MIN[OUT_W-1:0];
    end else begin
      w_out_man = r_acc[OUT_W-1:0];
    end
  end

  // Result fields are driven only in DONE, so they read zero in reset and while accumulating.
  always_comb begin
    bus.o_busy            = 1'b0;
    bus.o_result_valid    = 1'b0;
    bus.o_result_mantissa = '0;
    bus.o_result_exponent = '0;
    bus.o_sat             = 1'b0;
    bus.o_err_drop        = r_err_drop;
    case (r_state)
      ST_ACCUM: bus.o_busy = 1'b1;
      ST_DONE: begin
        bus.o_result_valid    = 1'b1;
        bus.o_result_mantissa = w_out_man;
        bus.o_result_exponent = r_exp;
        bus.o_sat             = r_sat | w_clip_hi | w_clip_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gfp8_nv_accum.sv
// Self-checking bench for gfp8_nv_accum: scenario tasks drive jobs, a
// scoreboard queue holds expected results popped at each output handshake.
module tb_gfp8_nv_accum;
  import gfp8_pkg::*;

  localparam int ACC_W = 40;
  localparam int CNT_W = 8;
  localparam int OUT_W = 32;

  typedef struct packed {
    gfp_result_t res;
    logic        sat;
  } exp_t;

  typedef struct {
    int man;
    int e;
  } beat_t;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t mon_exp;

  always #5 i_clk = ~i_clk;

  gfp8_nv_accum_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) bus ();

  gfp8_nv_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  function automatic exp_t mk(input int m, input int e, input logic s);
    exp_t r;
    r.res.mantissa = 32'(m);
    r.res.exponent = 8'(e);
    r.sat          = s;
    return r;
  endfunction

  function automatic beat_t bt(input int m, input int e);
    beat_t b;
    b.man = m;
    b.e   = e;
    return b;
  endfunction

  // Reference model on 64-bit integers: align to the larger exponent, add, clip.
  function automatic exp_t model(input beat_t q[$]);
    longint acc = 0;
    longint m;
    int     ex = 0;
    int     sh;
    logic   sat = 1'b0;
    longint hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (ACC_W - 1));
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        acc = longint'(q[i].man);
        ex  = q[i].e;
      end else begin
        m = longint'(q[i].man);
        if (q[i].e > ex) begin
          sh = q[i].e - ex;
          if (sh >= ACC_W) acc = 0; else acc = acc >>> sh;
          ex = q[i].e;
        end else begin
          sh = ex - q[i].e;
          if (sh >= ACC_W) m = 0; else m = m >>> sh;
        end
        acc = acc + m;
        if (acc > hi) begin acc = hi; sat = 1'b1; end
        if (acc < lo) begin acc = lo; sat = 1'b1; end
      end
    end
    if (acc > 64'sd2147483647)  begin acc = 64'sd2147483647;  sat = 1'b1; end
    if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1'b1; end
    return mk(int'(acc), ex, sat);
  endfunction

  // Scoreboard monitor: mid-cycle, compare any result that is handshaking this cycle.
  always @(negedge i_clk) begin
    #2;
    if (i_reset_n && bus.o_result_valid && bus.i_result_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: result mant=%0d exp=%0d with no expected entry",
                 bus.o_result_mantissa, bus.o_result_exponent);
      end else begin
        mon_exp = sb_q.pop_front();
        n_checks += 3;
        if (bus.o_result_mantissa !== mon_exp.res.mantissa) begin
          n_fail++;
          $display("FAIL sb_mantissa: got %0d (0x%08h) want %0d (0x%08h)", bus.o_result_mantissa,
                   bus.o_result_mantissa, mon_exp.res.mantissa, mon_exp.res.mantissa);
        end
        if (bus.o_result_exponent !== mon_exp.res.exponent) begin
          n_fail++;
          $display("FAIL sb_exponent: got %0d want %0d", bus.o_result_exponent, mon_exp.res.exponent);
        end
        if (bus.o_sat !== mon_exp.sat) begin
          n_fail++;
          $display("FAIL sb_sat: got %b want %b", bus.o_sat, mon_exp.sat);
        end
      end
    end
  end

  task automatic cycle();
    @(negedge i_clk);
  endtask

  task automatic drive_beat(input int m, input int e);
    bus.i_nv_valid    = 1'b1;
    bus.i_nv_mantissa = 32'(m);
    bus.i_nv_exponent = 8'(e);
    cycle();
    bus.i_nv_valid    = 1'b0;
  endtask

  // Full job with exact latency checks; expected result is pushed as stimulus starts.
  task automatic run_job(input string name, input beat_t beats[$], input exp_t expv);
    sb_q.push_back(expv);
    bus.i_start  = 1'b1;
    bus.i_num_nv = CNT_W'(beats.size());
    cycle();
    bus.i_start  = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", name, bus.o_busy);
    end
    for (int i = 0; i < beats.size(); i++) begin
      if (i == beats.size() - 1) begin
        n_checks++;
        if (bus.o_result_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_valid: got %b want 0", name, bus.o_result_valid);
        end
      end
      drive_beat(beats[i].man, beats[i].e);
    end
    n_checks++;
    if (bus.o_result_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: valid=%b busy=%b want valid=1 busy=0", name,
               bus.o_result_valid, bus.o_busy);
    end
    bus.i_result_ready = 1'b1;
    cycle();
    bus.i_result_ready = 1'b0;
    n_checks++;
    if (bus.o_result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s back_to_idle: valid=%b want 0", name, bus.o_result_valid);
    end
  endtask

  task automatic test_reset();
    cycle();
    cycle();
    n_checks++;
    if ({bus.o_busy, bus.o_result_valid, bus.o_sat, bus.o_err_drop} !== 4'b0000 ||
        bus.o_result_mantissa !== 32'sd0 || bus.o_result_exponent !== 8'sd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b valid=%b sat=%b err=%b mant=%0d exp=%0d want all 0",
               bus.o_busy, bus.o_result_valid, bus.o_sat, bus.o_err_drop,
               bus.o_result_mantissa, bus.o_result_exponent);
    end
    i_reset_n = 1'b1;
    cycle();
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b want 0 0", bus.o_busy, bus.o_result_valid);
    end
  endtask

  task automatic test_align();
    beat_t q[$];
    q.push_back(bt(100, 2));
    q.push_back(bt(50, 3));
    q.push_back(bt(-8, 0));
    run_job("align", q, mk(99, 3, 1'b0));
  endtask

  task automatic test_saturation();
    beat_t q[$];
    for (int i = 0; i < 4; i++) q.push_back(bt(32'h7FFF_FFFF, 0));
    run_job("sat_pos", q, mk(32'h7FFF_FFFF, 0, 1'b1));
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(bt(32'h8000_0000, 0));
    run_job("sat_neg", q, mk(32'h8000_0000, 0, 1'b1));
  endtask

  task automatic test_large_shift();
    beat_t q[$];
    q.push_back(bt(-1, -128));
    q.push_back(bt(5, 127));
    run_job("large_shift", q, mk(5, 127, 1'b0));
  endtask

  task automatic test_zero_count();
    sb_q.push_back(mk(0, 0, 1'b0));
    bus.i_start  = 1'b1;
    bus.i_num_nv = '0;
    cycle();
    bus.i_start  = 1'b0;
    n_checks++;
    if (bus.o_result_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_done: valid=%b busy=%b want 1 0", bus.o_result_valid, bus.o_busy);
    end
    bus.i_result_ready = 1'b1;
    cycle();
    bus.i_result_ready = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_idle: busy=%b valid=%b want 0 0", bus.o_busy, bus.o_result_valid);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    int    n;
    for (int j = 0; j < 4; j++) begin
      q.delete();
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        q.push_back(bt(($urandom_range(0, 4) == 0) ? 0 : int'($urandom),
                       int'($urandom_range(0, 20)) - 10));
      end
      run_job("random", q, model(q));
    end
  endtask

  task automatic test_back_to_back();
    sb_q.push_back(mk(7, 0, 1'b0));
    bus.i_start  = 1'b1;
    bus.i_num_nv = CNT_W'(2);
    cycle();
    bus.i_start  = 1'b0;
    drive_beat(3, 0);
    drive_beat(4, 0);
    n_checks++;
    if (bus.o_err_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_err_clean: err_drop=%b want 0", bus.o_err_drop);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.o_result_valid !== 1'b1 || bus.o_result_mantissa !== 32'sd7 ||
          bus.o_result_exponent !== 8'sd0 || bus.o_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: valid=%b mant=%0d exp=%0d sat=%b want 1 7 0 0", i,
                 bus.o_result_valid, bus.o_result_mantissa, bus.o_result_exponent, bus.o_sat);
      end
      if (i == 2) drive_beat(1000, 5);
      else cycle();
    end
    n_checks++;
    if (bus.o_err_drop !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_err_drop: err_drop=%b want 1", bus.o_err_drop);
    end
    sb_q.push_back(mk(9, -2, 1'b0));
    bus.i_result_ready = 1'b1;
    bus.i_start        = 1'b1;
    bus.i_num_nv       = CNT_W'(1);
    cycle();
    bus.i_result_ready = 1'b0;
    bus.i_start        = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b1 || bus.o_result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_direct_accum: busy=%b valid=%b want 1 0", bus.o_busy, bus.o_result_valid);
    end
    drive_beat(9, -2);
    n_checks++;
    if (bus.o_result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_latency: valid=%b want 1", bus.o_result_valid);
    end
    bus.i_result_ready = 1'b1;
    cycle();
    bus.i_result_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    beat_t q[$];
    bus.i_start  = 1'b1;
    bus.i_num_nv = CNT_W'(4);
    cycle();
    bus.i_start  = 1'b0;
    drive_beat(11, 0);
    drive_beat(12, 0);
    #2;
    i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_busy, bus.o_result_valid, bus.o_sat, bus.o_err_drop} !== 4'b0000 ||
        bus.o_result_mantissa !== 32'sd0 || bus.o_result_exponent !== 8'sd0) begin
      n_fail++;
      $display("FAIL midjob_async_reset: busy=%b valid=%b sat=%b err=%b mant=%0d exp=%0d want all 0",
               bus.o_busy, bus.o_result_valid, bus.o_sat, bus.o_err_drop,
               bus.o_result_mantissa, bus.o_result_exponent);
    end
    cycle();
    i_reset_n = 1'b1;
    cycle();
    q.push_back(bt(7, 1));
    run_job("after_reset", q, mk(7, 1, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start        = 1'b0;
    bus.i_num_nv       = '0;
    bus.i_nv_valid     = 1'b0;
    bus.i_nv_mantissa  = '0;
    bus.i_nv_exponent  = '0;
    bus.i_result_ready = 1'b0;

    test_reset();
    test_align();
    test_saturation();
    test_large_shift();
    test_zero_count();
    test_random();
    test_back_to_back();
    test_reset_mid_job();

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected results never produced, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gfp8_nv_accum.md
Name: gfp8_nv_accum

Overview:
Downstream neighbour of gfp8_nv_dot. It accumulates a programmed number of native-vector dot results (signed mantissa plus signed exponent) along the K dimension into one GFP result. Exponents are aligned on every beat. The final result is presented on a valid/ready output to the result writer. There is one accumulation job per output element.

Parameters:
ACC_W, 40, internal signed accumulator mantissa width (≥ 33)
CNT_W, 8, width of the NV count / beat counter
OUT_W, 32, output mantissa width; must be ≤ ACC_W

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  start a job; sampled in IDLE, or in DONE on the cycle the output handshake completes
i_num_nv  in  CNT_W  number of NV beats in the job, latched on accepted i_start
i_nv_valid  in  1  one NV dot result present this cycle (no backpressure)
i_nv_mantissa  in  32  signed NV dot mantissa
i_nv_exponent  in  8  signed NV dot exponent
o_busy  out  1  high in ACCUM
o_result_valid  out  1  result available (DONE state)
i_result_ready  in  1  consumer accepts the result
o_result_mantissa  out  OUT_W  signed result, saturated from the accumulator
o_result_exponent  out  8  signed result exponent
o_sat  out  1  result was saturated to OUT_W; valid with o_result_valid
o_err_drop  out  1  sticky: i_nv_valid was seen outside ACCUM; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; accumulator, exponent and counter cleared.
  - All outputs 0: o_result_mantissa=0, o_result_exponent=0, o_sat=0, o_err_drop=0, o_busy=0, o_result_valid=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - i_start=1 latches i_num_nv into the remaining counter and clears the first-beat flag.
  - If i_num_nv=0: go to DONE with acc=0, exp=0.
  - Otherwise go to ACCUM.
- ACCUM, on i_nv_valid:
  - First beat: acc ← sign-extended mantissa, exp ← i_nv_exponent.
  - Later beats: compare exponents as signed values; max is the new exp.
  - Difference is computed in 9 bits (range 0..255).
  - The operand with the smaller exponent is arithmetically right-shifted by the difference. If the difference ≥ ACC_W, that operand becomes 0 (not −1).
  - Sum in ACC_W+1 bits, then saturate to ACC_W and set an internal sat flag on clip.
  - Counter decrements on each beat. The beat that brings it to 0 moves the state to DONE on the next edge.
  - Latency: last beat at cycle t gives o_result_valid=1 at t+1.
  - i_start in ACCUM is ignored.
- DONE:
  - o_result_valid=1. Mantissa, exponent and o_sat are held stable until i_result_ready=1.
  - o_result_mantissa = acc clipped to the signed OUT_W range.
  - o_sat = internal sat flag OR output clip.
  - Handshake (valid & ready) returns to IDLE.
  - If i_start=1 in the same cycle as the handshake, the new job is accepted directly, with the same IDLE rules, including the num_nv=0 case.
- Stray beats: i_nv_valid in IDLE or DONE is discarded and sets o_err_drop.
- Zero-mantissa beats still participate in exponent max; no normalisation is performed.
- Reset mid-job aborts immediately to IDLE; no partial result is emitted.

Decomposition:
- Shared package gfp8_pkg holds:
  - GFP8_EXP_W=8 and GFP8_NV_MAN_W=32 constants;
  - typedef gfp_result_t {mantissa, exponent};
  - the state enum accum_state_e.
- One natural sub-module: gfp_align_add. It is combinational: signed exponent compare, shift with the ≥ACC_W zero rule, saturating add, sat flag. It is reusable by later tile-level reduction stages.

Test Plan:
1. Basic alignment: num_nv=3; beats (100,e2), (50,e3), (−8,e0). Expect o_result_mantissa=99, exp=3, o_sat=0, with o_result_valid one cycle after the 3rd beat.
2. Output saturation: ACC_W=40, num_nv=4, all beats (0x7FFFFFFF, e0). Expect mantissa=0x7FFFFFFF, exp=0, o_sat=1. A negative variant with 0x80000000 ×4 expects 0x80000000 and o_sat=1.
3. Large shift: beats (−1, e=−128) then (5, e=127), num_nv=2. Expect mantissa=5, exp=127 (the −1 is shifted out to 0, not −1).
4. Zero count: i_start with num_nv=0. Expect DONE next cycle, mantissa=0, exp=0, o_busy never high.
5. Backpressure and back-to-back:
   - Hold i_result_ready=0 for 5 cycles; the result stays stable.
   - Assert ready together with i_start (num_nv=1). Expect a direct transition to ACCUM.
   - A stray i_nv_valid during the DONE stall expects o_err_drop=1, with that beat not accumulated.
6. Reset mid-job: assert i_reset_n=0 after 2 of 4 beats. All outputs go to 0 asynchronously. A new 1-beat job (7, e1) then yields exactly 7, e1.
